// File: rtl/sar_frame_controller.sv
// Frame sequencer for the pixel array and its SAR ADC.
// Runs erase, then expose, then a binary-search conversion of every row.
module sar_frame_controller #(
  parameter int rows          = 16,
  parameter int width         = 4,
  parameter int resolution    = 8,
  parameter int erase_cycles  = 5,
  parameter int expose_cycles = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cmp,
  output logic                  erase,
  output logic                  expose,
  output logic                  adc_enable,
  output logic [width:0]        decoder_select,
  output logic [resolution-1:0] dac_code,
  output logic [resolution-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ERASE  = 3'd1;
  localparam logic [2:0] EXPOSE = 3'd2;
  localparam logic [2:0] SAMPLE = 3'd3;
  localparam logic [2:0] TRIAL  = 3'd4;
  localparam logic [2:0] STORE  = 3'd5;

  localparam int CMAX = (erase_cycles > expose_cycles) ?
                        erase_cycles : expose_cycles;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = (resolution > 1) ? $clog2(resolution) : 1;
  localparam int RW   = width + 1;

  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [RW-1:0]         row;
  logic [BW-1:0]         bidx;
  logic [resolution-1:0] result;
  logic [resolution-1:0] held;
  logic [resolution-1:0] trial;
  logic                  last_row;
  logic                  in_conv;

  assign trial    = result | (resolution'(1) << bidx);
  assign last_row = (row == RW'(rows - 1));
  assign in_conv  = (state == SAMPLE) || (state == TRIAL) ||
                    (state == STORE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      row    <= '0;
      bidx   <= '0;
      result <= '0;
      held   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ERASE;
            cnt   <= '0;
            row   <= '0;
          end
        end
        ERASE: begin
          if (cnt == CW'(erase_cycles - 1)) begin
            state <= EXPOSE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EXPOSE: begin
          if (cnt == CW'(expose_cycles - 1)) begin
            state <= SAMPLE;
            cnt   <= '0;
            row   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SAMPLE: begin
          result <= '0;
          bidx   <= BW'(resolution - 1);
          state  <= TRIAL;
        end
        TRIAL: begin
          // lower bits of result are still clear, so keeping trial is exact
          if (cmp) result <= trial;
          if (bidx == '0) state <= STORE;
          else bidx <= bidx - 1'b1;
        end
        STORE: begin
          held <= result;
          if (last_row) begin
            state <= IDLE;
          end else begin
            row   <= row + 1'b1;
            state <= SAMPLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign erase          = (state == ERASE);
  assign expose         = (state == EXPOSE);
  assign adc_enable     = (state == SAMPLE) || (state == TRIAL);
  assign data_valid     = (state == STORE);
  assign done           = (state == STORE) && last_row;
  assign busy           = (state != IDLE);
  assign decoder_select = in_conv ? row : '0;
  assign dac_code       = (state == TRIAL) ? trial : '0;
  assign data_out       = (state == STORE) ? result : held;

endmodule

// File: tb/tb_sar_frame_controller.sv
// Directed bench for sar_frame_controller with a behavioural comparator.
// Default parameters: 5 erase, 255 expose, 16 rows of 8-bit conversion.
module tb_sar_frame_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       cmp;
  logic       erase;
  logic       expose;
  logic       adc_enable;
  logic [4:0] decoder_select;
  logic [7:0] dac_code;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       done;

  int         checks = 0;
  int         errors = 0;
  int         mode   = 0;
  logic [7:0] vin;

  always #5 clk = ~clk;

  sar_frame_controller dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cmp(cmp),
    .erase(erase),
    .expose(expose),
    .adc_enable(adc_enable),
    .decoder_select(decoder_select),
    .dac_code(dac_code),
    .data_out(data_out),
    .data_valid(data_valid),
    .busy(busy),
    .done(done)
  );

  // mode 0: vin=A5, 1: vin=17*row, 2: cmp stuck 1, 3: cmp stuck 0
  always_comb begin
    vin = 8'hA5;
    if (mode == 1) vin = 8'(17 * int'(decoder_select));
    if (mode == 2) cmp = 1'b1;
    else if (mode == 3) cmp = 1'b0;
    else cmp = (vin >= dac_code);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input int m, input int r);
    case (m)
      0:       return 8'hA5;
      1:       return 8'(17 * r);
      2:       return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] outs();
    return {5'd0, erase, expose, adc_enable, data_valid, done, busy,
            decoder_select, dac_code, data_out};
  endfunction

  task automatic run_frame(input int m, input bit poke, input bit hold);
    int ne = 0, nx = 0, nd = 0, cyc = 0, last = 0, ntr = 0;
    int bad_gap = 0, bad_data = 0, bad_row = 0, idle_seen = 0;
    bit fin = 0;
    logic [7:0] tr [8];
    logic [7:0] exp_tr [8];
    exp_tr = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    while (!fin && cyc < 2000) begin
      cyc++;
      if (poke) start = (cyc == 3 || cyc == 265);
      ne += int'(erase);
      nx += int'(expose);
      idle_seen += int'(!busy);
      if (adc_enable && dac_code != 8'h00 && ntr < 8) begin
        tr[ntr] = dac_code;
        ntr++;
      end
      if (data_valid) begin
        if (nd > 0 && cyc - last != 10) bad_gap++;
        if (data_out !== model(m, nd)) bad_data++;
        if (decoder_select !== 5'(nd)) bad_row++;
        last = cyc;
        nd++;
      end
      if (done) fin = 1;
      else @(negedge clk);
    end
    check($sformatf("m%0d done seen", m), 32'(fin), 1);
    check($sformatf("m%0d done with dv", m),
          {30'd0, done, data_valid}, 3);
    check($sformatf("m%0d erase cycles", m), ne, 5);
    check($sformatf("m%0d expose cycles", m), nx, 255);
    check($sformatf("m%0d dv count", m), nd, 16);
    check($sformatf("m%0d dv spacing", m), bad_gap, 0);
    check($sformatf("m%0d data", m), bad_data, 0);
    check($sformatf("m%0d row select", m), bad_row, 0);
    check($sformatf("m%0d frame length", m), cyc, 420);
    check($sformatf("m%0d busy", m), idle_seen, 0);
    if (m == 0) begin
      check("trial count", ntr, 8);
      for (int i = 0; i < 8; i++)
        check($sformatf("trial %0d", i), tr[i], exp_tr[i]);
    end
  endtask

  initial begin
    int k;
    int cnt;
    reset = 1'b1;
    start = 1'b0;
    #12;
    check("reset outputs", outs(), 0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(busy | erase);
    end
    check("idle without start", cnt, 0);

    run_frame(0, 1'b1, 1'b0);
    @(negedge clk);
    check("idle after done", 32'(busy), 0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      cnt += int'(erase | busy);
    end
    check("no restart from poke", cnt, 0);

    run_frame(1, 1'b0, 1'b0);
    @(negedge clk);
    run_frame(2, 1'b0, 1'b0);
    @(negedge clk);
    run_frame(3, 1'b0, 1'b0);
    @(negedge clk);

    run_frame(0, 1'b0, 1'b1);
    @(negedge clk);
    check("b2b idle gap", 32'(busy), 0);
    @(negedge clk);
    check("b2b erase", 32'(erase), 1);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    mode  = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(decoder_select == 5'd7 && adc_enable && dac_code != 8'h00)
           && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("reached row 7 trial", 32'(k < 2000), 1);
    #2 reset = 1'b1;
    #1 check("async reset", outs(), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      cnt += int'(data_valid | done | busy);
    end
    check("aborted frame quiet", cnt, 0);
    run_frame(1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
